fc_layer_engine: RTL and testbench
==================================

Name: fc_layer_engine

Overview:
- Parametrised fully-connected layer engine; one instance per MNIST layer (784->60, 60->30, 30->10).
- Each run reads activations from an input BRAM and int8 weights from a weight BRAM, and computes one dot product per neuron.
- Each result goes through optional ReLU and a right shift, then is written to an output BRAM.
- Optional argmax tracking gives the class index, so the output-layer instance can drive mnist_class.

Parameters:
- IN_SIZE, 784, number of input activations.
- OUT_SIZE, 60, number of neurons.
- LANES, 4, elements per 32-bit word (4 = packed uint8 activations and int8 weights; 1 = one element per word). Only 1 or 4 are legal.
- ACC_WIDTH, 32, signed accumulator width.
- OUT_SHIFT, 0, arithmetic right shift applied to the activated result.
- RELU_EN, 1, 1 = clamp negative accumulators to 0.
- IN_ADDR_WIDTH, 9; W_ADDR_WIDTH, 14; OUT_ADDR_WIDTH, 6: BRAM address widths.
- CLASS_WIDTH, 4, width of the argmax index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_run  in  1  start pulse, sampled only in IDLE.
- o_busy  out  1  high from the cycle after i_run is accepted until o_done.
- o_done  out  1  one-cycle pulse at end of run.
- o_in_addr  out  IN_ADDR_WIDTH  input BRAM read address.
- i_in_data  in  32  input BRAM read data, 1-cycle latency.
- o_w_addr  out  W_ADDR_WIDTH  weight BRAM read address.
- i_w_data  in  32  weight BRAM read data, 1-cycle latency.
- o_out_addr  out  OUT_ADDR_WIDTH  output BRAM write address.
- o_out_data  out  32  output write data.
- o_out_we  out  1  output write strobe.
- o_class  out  CLASS_WIDTH  argmax neuron index of the last completed run.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs are 0: o_busy, o_done, o_out_we, addresses, o_out_data, o_class.
  - Accumulator and argmax registers are cleared.
  - Reset mid-run aborts immediately; no further writes occur.
- K = ceil(IN_SIZE/LANES) words per neuron.
  - Input word k sits at address k.
  - Weight word k of neuron n sits at address n*K+k.
  - Output of neuron n is written to address n.
- Lane j of a word occupies bits [8j+7:8j], lane 0 = lowest element index.
- LANES=1:
  - Activation = i_in_data saturated to 255 if it exceeds 255.
  - Weight = i_w_data[7:0] as int8.
- Padding: lanes with element index >= IN_SIZE in the final word contribute 0 regardless of data.
- Products are uint8 x int8, sign-extended to ACC_WIDTH. Accumulation wraps in two's complement; there is no saturation.
- FSM states: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH for next neuron | DONE) -> IDLE.
  - IDLE: i_run==1 clears the neuron counter and argmax, then enters FETCH.
  - FETCH: K cycles, issuing addresses k=0..K-1; the accumulator clears on the first issue.
  - DRAIN: 2 cycles (BRAM latency + MAC register) to complete the last MAC.
  - WRITE: 1 cycle.
    - o_out_we=1, o_out_addr=n.
    - o_out_data = (RELU_EN && acc<0 ? 0 : acc) >>> OUT_SHIFT, sign-extended or truncated to 32 bits.
  - DONE: o_done=1 for 1 cycle, o_busy drops in the same cycle, then returns to IDLE.
- Per-neuron cost is exactly K+3 cycles. o_done asserts OUT_SIZE*(K+3)+1 cycles after the edge that accepts i_run.
- Argmax:
  - Compares the pre-ReLU, pre-shift signed accumulator.
  - Strictly greater replaces the current maximum, so on a tie the lowest index wins.
  - o_class updates only in DONE and holds until the next DONE or reset.
- i_run while busy is ignored. i_run in the same cycle as DONE is ignored; a new run needs i_run in IDLE.
- Address outputs hold their last value outside FETCH. o_out_we is 0 except in WRITE.

Test Plan:
- Packed run (IN_SIZE=8, OUT_SIZE=2, LANES=4, RELU_EN=1, OUT_SHIFT=0); inputs all 2.
  - Stimulus: neuron0 weights all 3; neuron1 weights all -1.
  - Required: writes addr0=48, addr1=0; o_class=0; o_done at cycle 2*(2+3)+1=11.
- Padding (IN_SIZE=6, LANES=4); garbage 0xFF in the unused lanes of word 1; inputs 1, weights 1.
  - Required: output=6, so padded lanes are ignored.
- Unpacked mode (LANES=1, IN_SIZE=3, RELU_EN=0, OUT_SHIFT=1).
  - Stimulus: inputs {300,10,0}, weights {-2,1,5}.
  - Required: acc=255*-2+10=-500 -> output 0xFFFFFF06 (-250).
- Argmax tie (OUT_SIZE=3); neuron accumulators {5,9,9}.
  - Required: o_class=1, and it updates only on the o_done cycle.
- Busy and restart: i_run pulsed mid-run, then again on the o_done cycle.
  - Required: both pulses ignored, only one run occurs; a later i_run in IDLE starts a second run with identical results.
- Reset mid-run: reset=0 for one cycle during FETCH of neuron 1.
  - Required: next cycle all outputs 0 and no o_out_we; a fresh i_run then completes normally.

Source files
------------

// File: rtl/fc_layer_engine.sv
// ============================================================================
// Module      : fc_layer_engine
// Description : Fully-connected layer engine. Streams activations and int8
//               weights from two BRAMs, computes one dot product per neuron,
//               applies optional ReLU and a right shift, writes each result to
//               an output BRAM and tracks the argmax neuron index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_layer_engine #(
    parameter int IN_SIZE        = 784,
    parameter int OUT_SIZE       = 60,
    parameter int LANES          = 4,
    parameter int ACC_WIDTH      = 32,
    parameter int OUT_SHIFT      = 0,
    parameter int RELU_EN        = 1,
    parameter int IN_ADDR_WIDTH  = 9,
    parameter int W_ADDR_WIDTH   = 14,
    parameter int OUT_ADDR_WIDTH = 6,
    parameter int CLASS_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_run,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [IN_ADDR_WIDTH-1:0]  o_in_addr,
    input  logic [31:0]               i_in_data,
    output logic [W_ADDR_WIDTH-1:0]   o_w_addr,
    input  logic [31:0]               i_w_data,
    output logic [OUT_ADDR_WIDTH-1:0] o_out_addr,
    output logic [31:0]               o_out_data,
    output logic                      o_out_we,
    output logic [CLASS_WIDTH-1:0]    o_class
);

    localparam int K = (IN_SIZE + LANES - 1) / LANES;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic [IN_ADDR_WIDTH-1:0]    k_q;
    logic [W_ADDR_WIDTH-1:0]     w_addr_q;
    logic [OUT_ADDR_WIDTH-1:0]   n_q;
    logic                        drain_q;
    logic                        dvld_q;
    logic                        dlast_q;
    logic                        prod_vld_q;
    logic signed [ACC_WIDTH-1:0] prod_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] best_acc_q;
    logic [CLASS_WIDTH-1:0]      best_idx_q;
    logic [CLASS_WIDTH-1:0]      class_q;

    logic                        w_k_last;
    logic                        w_n_last;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_act;
    logic signed [ACC_WIDTH-1:0] w_shift;
    logic                        w_take;
    logic [CLASS_WIDTH-1:0]      w_best_idx;

    assign w_k_last = (k_q == IN_ADDR_WIDTH'(K - 1));
    assign w_n_last = (n_q == OUT_ADDR_WIDTH'(OUT_SIZE - 1));

    // Lane products of the word returned by the BRAMs this cycle.
    if (LANES == 4) begin : g_packed
        localparam int LAST_LANES = IN_SIZE - (K - 1) * LANES;
        logic signed [16:0] w_p [4];
        logic [3:0]         w_keep;

        for (genvar j = 0; j < 4; j++) begin : g_lane
            assign w_p[j]    = signed'({1'b0, i_in_data[8*j +: 8]}) * signed'(i_w_data[8*j +: 8]);
            assign w_keep[j] = !(dlast_q && (j >= LAST_LANES));
        end

        always_comb begin
            w_sum = '0;
            for (int j = 0; j < 4; j++) begin
                if (w_keep[j]) w_sum = w_sum + ACC_WIDTH'(w_p[j]);
            end
        end
    end else begin : g_unpacked
        logic [7:0]         w_a;
        logic signed [16:0] w_p;
        logic               w_unused_ok;

        assign w_a         = (i_in_data > 32'd255) ? 8'hFF : i_in_data[7:0];
        assign w_p         = signed'({1'b0, w_a}) * signed'(i_w_data[7:0]);
        assign w_sum       = ACC_WIDTH'(w_p);
        assign w_unused_ok = &{1'b0, i_w_data[31:8]};
    end

    assign w_act      = ((RELU_EN != 0) && (acc_q < 0)) ? '0 : acc_q;
    assign w_shift    = w_act >>> OUT_SHIFT;
    assign w_take     = (n_q == '0) || (acc_q > best_acc_q);
    assign w_best_idx = w_take ? CLASS_WIDTH'(n_q) : best_idx_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_run) state_d = S_FETCH;
            S_FETCH: if (w_k_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_WRITE;
            S_WRITE: state_d = w_n_last ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            w_addr_q   <= '0;
            n_q        <= '0;
            drain_q    <= 1'b0;
            dvld_q     <= 1'b0;
            dlast_q    <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            best_acc_q <= '0;
            best_idx_q <= '0;
            class_q    <= '0;
        end else begin
            state_q    <= state_d;
            dvld_q     <= (state_q == S_FETCH);
            dlast_q    <= (state_q == S_FETCH) && w_k_last;
            prod_vld_q <= dvld_q;
            prod_q     <= w_sum;

            if (prod_vld_q) acc_q <= acc_q + prod_q;
            if ((state_q == S_FETCH) && (k_q == '0)) acc_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (i_run) begin
                        k_q        <= '0;
                        w_addr_q   <= '0;
                        n_q        <= '0;
                        best_acc_q <= '0;
                        best_idx_q <= '0;
                    end
                end
                S_FETCH: begin
                    drain_q <= 1'b0;
                    if (!w_k_last) begin
                        k_q      <= k_q + 1'b1;
                        w_addr_q <= w_addr_q + 1'b1;
                    end
                end
                S_DRAIN: drain_q <= 1'b1;
                S_WRITE: begin
                    if (w_take) best_acc_q <= acc_q;
                    best_idx_q <= w_best_idx;
                    // Class is published together with o_done.
                    if (w_n_last) begin
                        class_q <= w_best_idx;
                    end else begin
                        n_q      <= n_q + 1'b1;
                        k_q      <= '0;
                        w_addr_q <= w_addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign o_done     = (state_q == S_DONE);
    assign o_out_we   = (state_q == S_WRITE);
    assign o_out_addr = n_q;
    assign o_out_data = (state_q == S_WRITE) ? 32'(w_shift) : 32'd0;
    assign o_in_addr  = k_q;
    assign o_w_addr   = w_addr_q;
    assign o_class    = class_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
// ============================================================================
// Module      : tb_fc_layer_engine
// Description : Self-checking bench for three fc_layer_engine configurations
//               (packed, packed with padding, unpacked) against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_layer_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  run_v;
    logic [2:0]  busy, done, we;
    logic [8:0]  in_addr  [3];
    logic [13:0] w_addr   [3];
    logic [5:0]  out_addr [3];
    logic [31:0] out_data [3];
    logic [3:0]  cls      [3];
    logic [31:0] in_rd    [3];
    logic [31:0] w_rd     [3];
    logic [31:0] in_mem   [3][4];
    logic [31:0] w_mem    [3][8];
    logic [31:0] cap      [3][4];
    int          done_at  [3];

    int  n_chk = 0;
    int  n_err = 0;
    bit  m_run   [3] = '{0, 0, 0};
    int  m_cyc   [3] = '{0, 0, 0};
    bit  m_fresh [3] = '{0, 0, 0};
    int  m_cls   [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    fc_layer_engine #(.IN_SIZE(8), .OUT_SIZE(2), .LANES(4), .RELU_EN(1), .OUT_SHIFT(0)) u_pk (
        .clk(clk), .reset(rst_n), .i_run(run_v[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_in_addr(in_addr[0]), .i_in_data(in_rd[0]), .o_w_addr(w_addr[0]), .i_w_data(w_rd[0]),
        .o_out_addr(out_addr[0]), .o_out_data(out_data[0]), .o_out_we(we[0]), .o_class(cls[0]));

    fc_layer_engine #(.IN_SIZE(6), .OUT_SIZE(3), .LANES(4), .RELU_EN(1), .OUT_SHIFT(0)) u_pad (
        .clk(clk), .reset(rst_n), .i_run(run_v[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_in_addr(in_addr[1]), .i_in_data(in_rd[1]), .o_w_addr(w_addr[1]), .i_w_data(w_rd[1]),
        .o_out_addr(out_addr[1]), .o_out_data(out_data[1]), .o_out_we(we[1]), .o_class(cls[1]));

    fc_layer_engine #(.IN_SIZE(3), .OUT_SIZE(1), .LANES(1), .RELU_EN(0), .OUT_SHIFT(1)) u_un (
        .clk(clk), .reset(rst_n), .i_run(run_v[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_in_addr(in_addr[2]), .i_in_data(in_rd[2]), .o_w_addr(w_addr[2]), .i_w_data(w_rd[2]),
        .o_out_addr(out_addr[2]), .o_out_data(out_data[2]), .o_out_we(we[2]), .o_class(cls[2]));

    // Synchronous-read BRAMs, one cycle of latency.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            in_rd[i] <= in_mem[i][in_addr[i][1:0]];
            w_rd[i]  <= w_mem[i][w_addr[i][2:0]];
        end
    end

    function automatic int f_in(input int i);
        return (i == 0) ? 8 : (i == 1) ? 6 : 3;
    endfunction
    function automatic int f_out(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    function automatic int f_lanes(input int i);
        return (i == 2) ? 1 : 4;
    endfunction
    function automatic int f_k(input int i);
        return (f_in(i) + f_lanes(i) - 1) / f_lanes(i);
    endfunction

    // Element-wise dot product straight from the memory contents.
    function automatic int m_acc(input int i, input int n);
        int acc = 0;
        for (int e = 0; e < f_in(i); e++) begin
            int          word, lane, a;
            logic [31:0] iw, ww;
            logic signed [7:0] w8;
            word = e / f_lanes(i);
            lane = e % f_lanes(i);
            iw   = in_mem[i][word];
            ww   = w_mem[i][n * f_k(i) + word];
            if (f_lanes(i) == 4) begin
                a  = int'(iw[8*lane +: 8]);
                w8 = ww[8*lane +: 8];
            end else begin
                a  = (iw > 32'd255) ? 255 : int'(iw);
                w8 = ww[7:0];
            end
            acc = acc + a * int'(w8);
        end
        return acc;
    endfunction

    function automatic int m_outv(input int i, input int n);
        int v;
        v = m_acc(i, n);
        if (i != 2 && v < 0) v = 0;
        return (i == 2) ? (v >>> 1) : v;
    endfunction

    function automatic int m_argmax(input int i);
        int best = 0;
        for (int n = 1; n < f_out(i); n++)
            if (m_acc(i, n) > m_acc(i, best)) best = n;
        return best;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t got=%h exp=%h", nm, i, $time, got, exp);
        end
    endtask

    // Model of run acceptance, timing and class publication.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int tot;
            tot = f_out(i) * (f_k(i) + 3) + 1;
            if (!rst_n) begin
                m_run[i] <= 0; m_cyc[i] <= 0; m_fresh[i] <= 1; m_cls[i] <= 0;
            end else if (m_run[i]) begin
                if (m_cyc[i] == tot) begin
                    m_run[i] <= 0; m_cyc[i] <= 0;
                end else begin
                    m_cyc[i] <= m_cyc[i] + 1;
                    if (m_cyc[i] + 1 == tot) m_cls[i] <= m_argmax(i);
                end
            end else if (run_v[i]) begin
                m_run[i] <= 1; m_cyc[i] <= 1; m_fresh[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int k, per, tot, c, p, n;
            bit act, wexp;
            k    = f_k(i);
            per  = k + 3;
            tot  = f_out(i) * per + 1;
            c    = m_cyc[i];
            act  = m_run[i] && (c < tot);
            wexp = act && (c % per == 0);
            chk("busy", i, {31'b0, busy[i]}, {31'b0, act});
            chk("done", i, {31'b0, done[i]}, {31'b0, m_run[i] && c == tot});
            chk("we", i, {31'b0, we[i]}, {31'b0, wexp});
            chk("class", i, 32'(cls[i]), 32'(m_cls[i]));
            if (wexp) begin
                chk("out_addr", i, 32'(out_addr[i]), 32'(c / per - 1));
                chk("out_data", i, out_data[i], 32'(m_outv(i, c / per - 1)));
            end
            if (act) begin
                p = (c - 1) % per;
                n = (c - 1) / per;
                if (p < k) begin
                    chk("in_addr", i, 32'(in_addr[i]), 32'(p));
                    chk("w_addr", i, 32'(w_addr[i]), 32'(n * k + p));
                end
            end
            if (m_fresh[i]) begin
                chk("rst_in_addr", i, 32'(in_addr[i]), 32'd0);
                chk("rst_w_addr", i, 32'(w_addr[i]), 32'd0);
                chk("rst_out_addr", i, 32'(out_addr[i]), 32'd0);
                chk("rst_out_data", i, out_data[i], 32'd0);
            end
            if (we[i]) cap[i][out_addr[i][1:0]] = out_data[i];
            if (done[i]) done_at[i] = c;
        end
    end

    task automatic start(input logic [2:0] m);
        run_v = m;
        @(negedge clk);
        run_v = 3'b000;
    endtask

    task automatic clear_caps();
        for (int i = 0; i < 3; i++) begin
            done_at[i] = 0;
            for (int a = 0; a < 4; a++) cap[i][a] = 32'hDEADBEEF;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy != 3'b000 || done != 3'b000 || m_run[0] || m_run[1] || m_run[2]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++; n_err++;
            $display("FAIL timeout_idle busy=%b exp=000", busy);
        end
    endtask

    task automatic wait_pk_done();
        int t = 0;
        while (done[0] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_chk++; n_err++;
            $display("FAIL timeout_done got=%b exp=1", done[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 4; a++) in_mem[i][a] = 32'd0;
            for (int a = 0; a < 8; a++) w_mem[i][a]  = 32'd0;
        end
        clear_caps();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        in_mem[0][0] = 32'h02020202; in_mem[0][1] = 32'h02020202;
        w_mem[0][0]  = 32'h03030303; w_mem[0][1]  = 32'h03030303;
        w_mem[0][2]  = 32'hFFFFFFFF; w_mem[0][3]  = 32'hFFFFFFFF;
        in_mem[1][0] = 32'h01010101; in_mem[1][1] = 32'hFFFF0101;
        w_mem[1][0]  = 32'h01010101; w_mem[1][1]  = 32'hFFFF0101;
        w_mem[1][2]  = 32'h02020202; w_mem[1][3]  = 32'hFFFF0001;
        w_mem[1][4]  = 32'h02020202; w_mem[1][5]  = 32'hFFFF0001;
        in_mem[2][0] = 32'd300; in_mem[2][1] = 32'd10; in_mem[2][2] = 32'd0;
        w_mem[2][0]  = 32'h123456FE; w_mem[2][1] = 32'hABCDEF01; w_mem[2][2] = 32'h00000005;
        @(negedge clk);

        // All three engines together; stray run pulses mid-run and on o_done.
        start(3'b111);
        repeat (3) @(negedge clk);
        run_v[0] = 1'b1;
        @(negedge clk);
        run_v[0] = 1'b0;
        wait_pk_done();
        run_v[0] = 1'b1;
        @(negedge clk);
        run_v[0] = 1'b0;
        wait_idle();
        chk("pk_n0", 0, cap[0][0], 32'd48);
        chk("pk_n1", 0, cap[0][1], 32'd0);
        chk("pk_class", 0, 32'(cls[0]), 32'd0);
        chk("pk_done_at", 0, 32'(done_at[0]), 32'd11);
        chk("pad_n0", 1, cap[1][0], 32'd6);
        chk("pad_n1", 1, cap[1][1], 32'd9);
        chk("pad_class", 1, 32'(cls[1]), 32'd1);
        chk("un_n0", 2, cap[2][0], 32'hFFFFFF06);
        chk("un_done_at", 2, 32'(done_at[2]), 32'd7);

        // Second run of the packed engine gives identical results.
        clear_caps();
        start(3'b001);
        wait_idle();
        chk("pk2_n0", 0, cap[0][0], 32'd48);
        chk("pk2_n1", 0, cap[0][1], 32'd0);
        chk("pk2_done_at", 0, 32'(done_at[0]), 32'd11);

        // Argmax tie {5,9,9}: lowest index wins.
        clear_caps();
        w_mem[1][1] = 32'hFFFF0001;
        start(3'b010);
        wait_idle();
        chk("tie_n0", 1, cap[1][0], 32'd5);
        chk("tie_class", 1, 32'(cls[1]), 32'd1);
        chk("tie_done_at", 1, 32'(done_at[1]), 32'd16);

        // Reset during FETCH of neuron 1, then a clean run.
        clear_caps();
        start(3'b001);
        for (int t = 0; t < 50 && m_cyc[0] != 6; t++) @(negedge clk);
        chk("reach_fetch_n1", 0, 32'(m_cyc[0]), 32'd6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_n1_unwritten", 0, cap[0][1], 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        start(3'b001);
        wait_idle();
        chk("post_rst_n0", 0, cap[0][0], 32'd48);
        chk("post_rst_n1", 0, cap[0][1], 32'd0);
        chk("post_rst_class", 0, 32'(cls[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
